special_classify_pipe: RTL and testbench
========================================

Name: special_classify_pipe

Overview:
- Parametrised successor of the fp16 sqrt special-case stage. Sits at the front of the square-root datapath.
- Classifies an IEEE-754 operand of any EXP_W/MANT_W width and resolves sqrt special results: NaN, ±inf, ±0 and negative operands.
- Provides a 2-stage valid/ready pipeline with full backpressure and a sticky invalid-operation (NV) flag.
- Non-special operands leave with bypass=0 for the iterative sqrt core. Special operands leave with the final result and bypass=1.

Parameters:
- EXP_W, 5, exponent field width (≥3).
- MANT_W, 10, fraction field width (≥2).
- BIAS, 2**(EXP_W-1)-1, exponent bias.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  stage 1 can accept.
- in_data  in  1+EXP_W+MANT_W  {sign, exp, mant}.
- out_valid  out  1  stage 2 holds a result.
- out_ready  in  1  downstream accepts.
- out_data  out  1+EXP_W+MANT_W  resolved special result, or operand passthrough.
- out_exp_adj  out  EXP_W+2  signed unbiased exponent of the operand.
- out_mant  out  MANT_W  fraction for the sqrt core.
- out_class  out  6  one-hot {qnan, snan, inf, zero, subnormal, normal}.
- out_bypass  out  1  out_data is final; skip the core.
- clr_flags  in  1  clear the sticky flags.
- flag_nv  out  1  sticky invalid-operation flag.

Behaviour:
- Reset: clears both stage valid bits and flag_nv. All data/class outputs are 0, so out_valid=0 and in_ready=1 after reset.
- Handshake and latency:
  - Transfer occurs on valid&ready.
  - Stage k advances when !vld_k || ready_{k+1}.
  - in_ready = !vld1 || !vld2 || out_ready, i.e. combinational through both stages.
  - Latency is 2 cycles with no stall; sustained throughput is 1 per cycle.
  - out_data and all out_* fields are stable while out_valid && !out_ready.
- Stage 1 registers the fields and class. Class definitions:
  - qnan: exp all ones, mant≠0, mant MSB=1.
  - snan: exp all ones, mant≠0, mant MSB=0.
  - inf: exp all ones, mant=0.
  - zero: exp=0, mant=0.
  - subnormal: exp=0, mant≠0.
  - normal: all other operands.
- Stage 2 resolves the result:
  - NaN (q or s): sign kept, exp all ones, mant | quiet-bit; bypass=1.
  - Negative and not zero (including -inf and negative subnormal): canonical qNaN with sign=1, exp all ones, mant=quiet-bit only; bypass=1.
  - ±0: result equals the input (-0 stays -0); bypass=1.
  - +inf: result +inf; bypass=1.
  - Positive normal or subnormal: out_data = input; bypass=0.
- Exponent and fraction outputs:
  - out_exp_adj = exp - BIAS for normal operands, and 1 - BIAS for subnormal operands.
  - out_mant = raw fraction (see Optional Feature).
- flag_nv:
  - Set at the stage-2 output transfer (out_valid && out_ready) of an snan or negative-nonzero operand.
  - clr_flags clears the flag.
  - Simultaneous set and clr in one cycle: set wins, so flag_nv=1.
- Reset mid-operation drops both in-flight operands with no output transfer. flag_nv clears.
- Stall with a full pipe: in_ready=0, both stages hold, and no operand is lost or duplicated.

Optional Feature:
- Macro: SPECIAL_SUBNORM_NORM_EN.
- When defined, stage 2 normalises subnormal operands:
  - Shift count s = leading-zero count of mant plus 1.
  - out_mant = mant << s, truncated to MANT_W bits, which drops the implicit 1.
  - out_exp_adj = 1 - BIAS - s.
  - out_class still reports subnormal.
- When not defined, subnormal operands pass with the raw fraction and out_exp_adj = 1 - BIAS. No LZC logic is synthesised.

Decomposition:
- Package special_pkg holds:
  - class index constants (CLS_QNAN..CLS_NORMAL);
  - a function returning the quiet-bit mask;
  - a function returning the canonical-NaN encoding, both parametrised by EXP_W/MANT_W.
- Sub-module lzc_n (parameter WIDTH) provides the leading-zero count. It is instantiated only under SPECIAL_SUBNORM_NORM_EN.

Test Plan:
- 0x7C00, out_ready=1 -> 2 cycles later out_data=0x7C00, class=inf, bypass=1, flag_nv=0.
- 0xFC00 -> out_data=0xFE00, bypass=1, flag_nv becomes 1 after the transfer; then clr_flags -> flag_nv=0. Set and clr in the same cycle -> flag_nv=1.
- Signed zero and NaNs:
  - 0x8000 -> out_data=0x8000, class=zero.
  - 0x7D00 (snan) -> out_data=0x7F00, flag_nv=1.
  - 0xFE01 (qnan) -> out_data=0xFE01, flag_nv unchanged.
- 0x3C00 -> out_data=0x3C00, bypass=0, out_exp_adj=0, out_mant=0. Back-to-back stream of 0x3C00, 0x4000, 0x4400 -> one result per cycle.
- Backpressure:
  - Stream 4 operands with out_ready=0 for 5 cycles: in_ready drops after 2 accepts; outputs stay stable.
  - Release out_ready: all 4 operands emerge in order, no loss or duplication.
  - Assert rst mid-stream: out_valid=0 on the next cycle.
- 0x0001 with SPECIAL_SUBNORM_NORM_EN -> out_mant=0, out_exp_adj=-24. Without the macro -> out_mant=0x001, out_exp_adj=-14.

Source files
------------

// File: rtl/special_pkg.sv
// rtl/special_pkg.sv - shared constants and encodings for the sqrt special-case stage
//
// Holds the one-hot class bit positions used on out_class and two helpers
// that build the quiet-bit mask and the canonical (negative, quiet) NaN for
// any exponent/fraction width. The helpers return wide vectors; callers
// slice the low bits they need.
package special_pkg;

    // Bit positions inside the 6-bit one-hot class vector
    // {qnan, snan, inf, zero, subnormal, normal}.
    localparam int CLS_NORMAL    = 0;
    localparam int CLS_SUBNORMAL = 1;
    localparam int CLS_ZERO      = 2;
    localparam int CLS_INF       = 3;
    localparam int CLS_SNAN      = 4;
    localparam int CLS_QNAN      = 5;
    localparam int CLS_W         = 6;

    // Fraction MSB, the IEEE-754 quiet bit.
    function automatic logic [63:0] quiet_mask(input int mant_w);
        return 64'd1 << (mant_w - 1);
    endfunction

    // Canonical NaN produced for invalid sqrt operands:
    // sign=1, exponent all ones, fraction = quiet bit only.
    function automatic logic [127:0] canon_nan(input int exp_w, input int mant_w);
        logic [127:0] r;
        r = (128'd1 << (exp_w + mant_w))
          | (((128'd1 << exp_w) - 128'd1) << mant_w)
          | (128'd1 << (mant_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/lzc_n.sv
// rtl/lzc_n.sv - leading-zero counter for the subnormal normaliser
//
// Ports:
//   in_bits  in   WIDTH               vector to scan from the MSB down
//   count    out  $clog2(WIDTH+1)     number of leading zeros (WIDTH when all zero)
module lzc_n #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0]         in_bits,
    output logic [$clog2(WIDTH+1)-1:0] count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Ascending scan: the last set bit seen is the highest one, so its
    // distance from the MSB is the leading-zero count.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_bits[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/special_classify_pipe.sv
// rtl/special_classify_pipe.sv - 2-stage IEEE-754 classify and sqrt special-result pipe
//
// Front end of the square-root datapath. Stage 1 registers the operand and
// its class; stage 2 resolves sqrt special results (NaN, +-inf, +-0,
// negative operands) and presents positive normal/subnormal operands to
// the iterative core with bypass=0.
//
// Optional feature macro: SPECIAL_SUBNORM_NORM_EN
//   defined   - stage 2 normalises subnormal fractions through lzc_n
//   undefined - subnormals pass with the raw fraction, no LZC logic
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/in_ready/in_data      operand stream {sign, exp, mant}
//   out_valid/out_ready/out_data   result stream (final value or passthrough)
//   out_exp_adj    signed unbiased exponent of the operand (EXP_W+2 bits)
//   out_mant       fraction handed to the sqrt core
//   out_class      one-hot {qnan, snan, inf, zero, subnormal, normal}
//   out_bypass     out_data is final, skip the core
//   clr_flags      clear sticky flags
//   flag_nv        sticky invalid-operation flag
module special_classify_pipe
    import special_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10,
    parameter int BIAS   = 2 ** (EXP_W - 1) - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+MANT_W:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     out_data,
    output logic [EXP_W+1:0]          out_exp_adj,
    output logic [MANT_W-1:0]         out_mant,
    output logic [CLS_W-1:0]          out_class,
    output logic                      out_bypass,
    input  logic                      clr_flags,
    output logic                      flag_nv
);

    localparam int DW  = 1 + EXP_W + MANT_W;
    localparam int EAW = EXP_W + 2;

    localparam logic [63:0]     QMASK_W = quiet_mask(MANT_W);
    localparam logic [MANT_W-1:0] QMASK = QMASK_W[MANT_W-1:0];
    localparam logic [127:0]    CNAN_W  = canon_nan(EXP_W, MANT_W);
    localparam logic [DW-1:0]   CNAN    = CNAN_W[DW-1:0];
    localparam logic [EAW-1:0]  BIAS_E  = EAW'(BIAS);

    // ------------------------------------------------------------------
    // Handshake: each stage advances when empty or when the next one moves,
    // so in_ready looks through both stages to out_ready.
    // ------------------------------------------------------------------
    logic vld1;
    logic vld2;
    logic adv1;
    logic adv2;

    assign adv2      = !vld2 || out_ready;
    assign adv1      = !vld1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = vld2;

    // ------------------------------------------------------------------
    // Stage 1: classify
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_exp_ones;
    logic              in_exp_zero;
    logic              in_mant_zero;
    logic [CLS_W-1:0]  in_class;

    assign in_exp       = in_data[DW-2:MANT_W];
    assign in_mant      = in_data[MANT_W-1:0];
    assign in_exp_ones  = &in_exp;
    assign in_exp_zero  = ~|in_exp;
    assign in_mant_zero = ~|in_mant;

    always_comb begin
        in_class = '0;
        if (in_exp_ones) begin
            if (in_mant_zero) begin
                in_class[CLS_INF] = 1'b1;
            end else if (in_mant[MANT_W-1]) begin
                in_class[CLS_QNAN] = 1'b1;
            end else begin
                in_class[CLS_SNAN] = 1'b1;
            end
        end else if (in_exp_zero) begin
            if (in_mant_zero) begin
                in_class[CLS_ZERO] = 1'b1;
            end else begin
                in_class[CLS_SUBNORMAL] = 1'b1;
            end
        end else begin
            in_class[CLS_NORMAL] = 1'b1;
        end
    end

    logic [DW-1:0]    s1_data;
    logic [CLS_W-1:0] s1_class;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld1     <= 1'b0;
            s1_data  <= '0;
            s1_class <= '0;
        end else if (adv1) begin
            vld1 <= in_valid;
            if (in_valid) begin
                s1_data  <= in_data;
                s1_class <= in_class;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: resolve special results
    // ------------------------------------------------------------------
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W-1:0] s1_mant;
    logic [EAW-1:0]    norm_exp;
    logic [EAW-1:0]    sub_exp;
    logic [MANT_W-1:0] sub_mant;

    assign s1_sign  = s1_data[DW-1];
    assign s1_exp   = s1_data[DW-2:MANT_W];
    assign s1_mant  = s1_data[MANT_W-1:0];
    assign norm_exp = {2'b00, s1_exp} - BIAS_E;

`ifdef SPECIAL_SUBNORM_NORM_EN
    localparam int CW = $clog2(MANT_W + 1);

    logic [CW-1:0] lz;
    logic [CW:0]   shamt;

    lzc_n #(
        .WIDTH (MANT_W)
    ) u_lzc (
        .in_bits (s1_mant),
        .count   (lz)
    );

    // Shifting one past the leading zeros pushes the leading 1 out of the
    // field, leaving the fraction below the now-implicit bit.
    assign shamt    = {1'b0, lz} + (CW + 1)'(1);
    assign sub_mant = s1_mant << shamt;
    assign sub_exp  = EAW'(1) - BIAS_E - EAW'(shamt);
`else
    assign sub_mant = s1_mant;
    assign sub_exp  = EAW'(1) - BIAS_E;
`endif

    logic [DW-1:0]     r_data;
    logic [EAW-1:0]    r_exp_adj;
    logic [MANT_W-1:0] r_mant;
    logic              r_bypass;
    logic              r_nv;

    // Priority: NaNs keep their sign (negative qNaN is not invalid), then
    // any other negative non-zero operand becomes the canonical NaN.
    // Special classes report exp_adj = 0 since the core never sees them.
    always_comb begin
        r_data    = s1_data;
        r_exp_adj = '0;
        r_mant    = s1_mant;
        r_bypass  = 1'b1;
        r_nv      = 1'b0;
        if (s1_class[CLS_QNAN] || s1_class[CLS_SNAN]) begin
            r_data = {s1_sign, {EXP_W{1'b1}}, s1_mant | QMASK};
            r_nv   = s1_class[CLS_SNAN];
        end else if (s1_sign && !s1_class[CLS_ZERO]) begin
            r_data = CNAN;
            r_nv   = 1'b1;
        end else if (s1_class[CLS_NORMAL] || s1_class[CLS_SUBNORMAL]) begin
            r_bypass = 1'b0;
        end

        if (s1_class[CLS_NORMAL]) begin
            r_exp_adj = norm_exp;
        end else if (s1_class[CLS_SUBNORMAL]) begin
            r_exp_adj = sub_exp;
            r_mant    = sub_mant;
        end
    end

    logic s2_nv;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld2        <= 1'b0;
            out_data    <= '0;
            out_exp_adj <= '0;
            out_mant    <= '0;
            out_class   <= '0;
            out_bypass  <= 1'b0;
            s2_nv       <= 1'b0;
        end else if (adv2) begin
            vld2 <= vld1;
            if (vld1) begin
                out_data    <= r_data;
                out_exp_adj <= r_exp_adj;
                out_mant    <= r_mant;
                out_class   <= s1_class;
                out_bypass  <= r_bypass;
                s2_nv       <= r_nv;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky NV: raised when an invalid operand actually leaves; a raise
    // in the same cycle as a clear takes priority.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_nv <= 1'b0;
        end else if (vld2 && out_ready && s2_nv) begin
            flag_nv <= 1'b1;
        end else if (clr_flags) begin
            flag_nv <= 1'b0;
        end
    end

endmodule

// File: tb/tb_special_classify_pipe.sv
// tb/tb_special_classify_pipe.sv - scoreboard bench for special_classify_pipe (fp16)
module tb_special_classify_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [6:0]  out_exp_adj;
    logic [9:0]  out_mant;
    logic [5:0]  out_class;
    logic        out_bypass;
    logic        clr_flags;
    logic        flag_nv;

    special_classify_pipe #(
        .EXP_W  (5),
        .MANT_W (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_exp_adj (out_exp_adj),
        .out_mant    (out_mant),
        .out_class   (out_class),
        .out_bypass  (out_bypass),
        .clr_flags   (clr_flags),
        .flag_nv     (flag_nv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [5:0]  cls;
        logic        bp;
        logic [6:0]  ea;
        logic [9:0]  mant;
        logic        nv;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   lat_q[$];
    int   pop_q[$];
    int   n_out = 0;
    logic exp_nv = 1'b0;
    bit   mon_en = 0;
    bit   rand_rdy = 0;

    // Reference model of one fp16 operand.
    function automatic exp_t model(input logic [15:0] d, input int c);
        exp_t r;
        logic s;
        logic [4:0] e;
        logic [9:0] m;
        s = d[15];
        e = d[14:10];
        m = d[9:0];
        if (e == 5'h1f)      r.cls = (m == 0) ? 6'b001000 : (m[9] ? 6'b100000 : 6'b010000);
        else if (e == 5'h00) r.cls = (m == 0) ? 6'b000100 : 6'b000010;
        else                 r.cls = 6'b000001;
        r.mant = m;
        r.ea   = 7'd0;
        if (r.cls == 6'b000001) r.ea = 7'(int'(e) - 15);
        if (r.cls == 6'b000010) begin
`ifdef SPECIAL_SUBNORM_NORM_EN
            int p;
            int sh;
            p = 0;
            for (int i = 0; i < 10; i++) if (m[i]) p = i;
            sh = 10 - p;
            r.mant = 10'(m << sh);
            r.ea   = 7'(-14 - sh);
`else
            r.ea = 7'(-14);
`endif
        end
        if (r.cls[5] || r.cls[4]) r.data = {s, 5'h1f, m | 10'h200};
        else if (s && !r.cls[2])  r.data = 16'hFE00;
        else                      r.data = d;
        r.bp  = !(!s && (r.cls[0] || r.cls[1]));
        r.nv  = r.cls[4] || (s && !r.cls[2] && !r.cls[5]);
        r.cyc = c;
        return r;
    endfunction

    // Monitor: compares the held output against the scoreboard head every
    // cycle it is valid, pops on transfer, tracks the expected sticky flag.
    initial begin
        exp_t e;
        logic nv_next;
        wait (mon_en);
        forever begin
            @(negedge clk);
            check("flag_nv", flag_nv, exp_nv);
            nv_next = exp_nv;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("out_valid_unexpected", out_valid, 0);
                end else begin
                    e = sb[0];
                    check("out_data", out_data, e.data);
                    check("out_class", out_class, e.cls);
                    check("out_bypass", out_bypass, e.bp);
                    check("out_exp_adj", out_exp_adj, e.ea);
                    check("out_mant", out_mant, e.mant);
                    if (out_ready && !rst) begin
                        void'(sb.pop_front());
                        lat_q.push_back(cyc - e.cyc);
                        pop_q.push_back(cyc);
                        n_out++;
                        if (e.nv) nv_next = 1'b1;
                        else if (clr_flags) nv_next = 1'b0;
                    end else if (clr_flags) begin
                        nv_next = 1'b0;
                    end
                end
            end else if (clr_flags) begin
                nv_next = 1'b0;
            end
            if (rst) begin
                nv_next = 1'b0;
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back(model(in_data, cyc));
            end
            exp_nv = nv_next;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    logic [15:0] ops[4];
    int idx;
    bit tk;
    int n0;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_flag_nv", flag_nv, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_class", out_class, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // +inf, then -inf setting NV, clear, then set/clear collision
        send(16'h7C00);
        drain();
        check("inf_nv", flag_nv, 0);
        send(16'hFC00);
        drain();
        @(posedge clk);
        #1;
        check("neg_inf_nv", flag_nv, 1);
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        check("nv_cleared", flag_nv, 0);

        out_ready = 1'b0;
        send(16'hFC00);
        @(posedge clk);
        #1;
        check("stall_valid", out_valid, 1);
        clr_flags = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("nv_set_wins", flag_nv, 1);
        @(posedge clk);
        #1;
        check("nv_clr_after", flag_nv, 0);
        clr_flags = 1'b0;

        // signed zero and NaNs
        send(16'h8000);
        send(16'h7D00);
        send(16'hFE01);
        send(16'h0000);
        drain();
        check("nan_nv", flag_nv, 1);

        // back-to-back normals: one result per cycle, latency 2
        lat_q.delete();
        pop_q.delete();
        send(16'h3C00);
        send(16'h4000);
        send(16'h4400);
        drain();
        check("tp_count", lat_q.size(), 3);
        if (lat_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check("tp_latency", lat_q[i], 2);
            check("tp_gap01", pop_q[1] - pop_q[0], 1);
            check("tp_gap12", pop_q[2] - pop_q[1], 1);
        end

        // subnormals, including the smallest and a negative one
        send(16'h0001);
        send(16'h03FF);
        send(16'h0155);
        send(16'h8001);
        drain();

        // backpressure with a 4-operand stream
        n0 = n_out;
        ops[0] = 16'h3C00;
        ops[1] = 16'h4000;
        ops[2] = 16'hC400;
        ops[3] = 16'h3555;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        in_data = ops[0];
        repeat (5) begin
            @(negedge clk);
            tk = in_ready;
            @(posedge clk);
            #1;
            if (tk) begin
                idx++;
                if (idx < 4) in_data = ops[idx];
                else in_valid = 1'b0;
            end
        end
        check("bp_accepts", idx, 2);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && idx < 4; n++) begin
            @(negedge clk);
            tk = in_ready;
            @(posedge clk);
            #1;
            if (tk) begin
                idx++;
                if (idx < 4) in_data = ops[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        drain();
        check("bp_out_count", n_out - n0, 4);

        // reset with two operands in flight and NV set
        send(16'hBC00);
        drain();
        out_ready = 1'b0;
        send(16'h3C00);
        send(16'h4000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", in_ready, 1);
        check("rst_mid_nv", flag_nv, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // random operands under random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) send(16'($urandom));
        rand_rdy = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
